// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_CNT_W = 16;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Register bundle at the default counter width and channel count; the top
    // declares its own copy sized from its parameters.
    typedef struct packed {
        logic [PWM_CNT_W-1:0]     period;
        logic [4*PWM_CNT_W-1:0]   duty;
        pwm_mode_e                mode;
    } pwm_cfg_t;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: duty compare, polarity inversion and output register.
module pwm_channel_cmp #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic [CNT_W-1:0] duty_i,
    input  logic             polarity_i,
    output logic             pwm_o
);

    logic raw;

    assign raw = en_i && (cnt_i < duty_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_o <= 1'b0;
        end else begin
            pwm_o <= raw ^ polarity_i;
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with a shared edge/center-aligned counter and
// double-buffered period/duty/mode that switch only at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = PWM_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [CNT_W-1:0]        period,
    input  logic [NUM_CH*CNT_W-1:0] duty,
    input  logic                    mode,
    input  logic [NUM_CH-1:0]       polarity,
    input  logic                    update,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_tick
);

    typedef struct packed {
        logic [CNT_W-1:0]        period;
        logic [NUM_CH*CNT_W-1:0] duty;
        pwm_mode_e               mode;
    } cfg_t;

    cfg_t             active_q;
    cfg_t             shadow_q;
    cfg_t             cfg_in;
    logic             pending_q;
    logic [CNT_W-1:0] cnt_q;
    logic             dir_down_q;
    logic             tick_q;

    logic [CNT_W-1:0] period_last;
    logic             run;
    logic             at_boundary;
    logic             load_pt;

    always_comb begin
        cfg_in.period = period;
        cfg_in.duty   = duty;
        cfg_in.mode   = pwm_mode_e'(mode);
    end

    always_comb begin
        period_last = active_q.period - CNT_W'(1);
        run         = enable && (active_q.period != '0);
        if (active_q.mode == PWM_CENTER) begin
            at_boundary = dir_down_q && (cnt_q == '0);
        end else begin
            at_boundary = (cnt_q == period_last);
        end
        // Idle (disabled or zero period) behaves as a boundary on every cycle.
        load_pt = !run || at_boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active_q   <= '0;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            cnt_q      <= '0;
            dir_down_q <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            tick_q <= run && at_boundary;

            if (update) begin
                shadow_q <= cfg_in;
            end
            if (load_pt && update) begin
                active_q  <= cfg_in;
                pending_q <= 1'b0;
            end else if (load_pt && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end else if (update) begin
                pending_q <= 1'b1;
            end

            // Both modes restart at 0 counting up after a boundary.
            if (load_pt) begin
                cnt_q      <= '0;
                dir_down_q <= 1'b0;
            end else if (active_q.mode == PWM_EDGE) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else if (!dir_down_q) begin
                if (cnt_q == period_last) begin
                    dir_down_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign period_tick = tick_q;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        pwm_channel_cmp #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i      (clk),
            .rst_i      (rst),
            .en_i       (run),
            .cnt_i      (cnt_q),
            .duty_i     (active_q.duty[k*CNT_W +: CNT_W]),
            .polarity_i (polarity[k]),
            .pwm_o      (pwm_out[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with a phase-based reference model checked every cycle.
module tb_pwm_multi;

    localparam int NCH = 4;
    localparam int W   = 16;

    logic             clk;
    logic             rst;
    logic             enable;
    logic [W-1:0]     period;
    logic [NCH*W-1:0] duty;
    logic             mode;
    logic [NCH-1:0]   polarity;
    logic             update;
    logic [NCH-1:0]   pwm_out;
    logic             period_tick;

    pwm_multi #(
        .NUM_CH(NCH),
        .CNT_W (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .period     (period),
        .duty       (duty),
        .mode       (mode),
        .polarity   (polarity),
        .update     (update),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: position t within a period of length P (edge) or 2P (center).
    int         a_p, a_mode, s_p, s_mode, m_t;
    int         a_duty[NCH];
    int         s_duty[NCH];
    bit         m_pend;
    bit         mvalid = 1'b0;
    logic [NCH-1:0] exp_pwm;
    logic       exp_tick;
    int         m_len, m_cnt;
    bit         m_run, m_last;

    always @(posedge clk) begin
        if (rst) begin
            a_p = 0; a_mode = 0; s_p = 0; s_mode = 0; m_t = 0; m_pend = 1'b0;
            for (int k = 0; k < NCH; k++) begin
                a_duty[k] = 0;
                s_duty[k] = 0;
            end
            exp_pwm  = '0;
            exp_tick = 1'b0;
        end else begin
            m_len  = (a_mode != 0) ? 2 * a_p : a_p;
            m_run  = enable && (a_p != 0);
            m_cnt  = (m_t < a_p) ? m_t : 2 * a_p - 1 - m_t;
            m_last = !m_run || (m_t == m_len - 1);
            for (int k = 0; k < NCH; k++) begin
                exp_pwm[k] = (m_run && (m_cnt < a_duty[k])) ^ polarity[k];
            end
            exp_tick = m_run && (m_t == m_len - 1);
            if (update) begin
                s_p    = int'(period);
                s_mode = int'(mode);
                for (int k = 0; k < NCH; k++) s_duty[k] = int'(duty[k*W +: W]);
            end
            if (m_last) begin
                if (update || m_pend) begin
                    a_p    = s_p;
                    a_mode = s_mode;
                    for (int k = 0; k < NCH; k++) a_duty[k] = s_duty[k];
                end
                m_pend = 1'b0;
                m_t    = 0;
            end else begin
                if (update) m_pend = 1'b1;
                m_t++;
            end
        end
        mvalid = 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (pwm_out !== exp_pwm) begin
                errors++;
                $display("FAIL model_pwm t=%0t got %b expected %b", $time, pwm_out, exp_pwm);
            end
            checks++;
            if (period_tick !== exp_tick) begin
                errors++;
                $display("FAIL model_tick t=%0t got %b expected %b", $time, period_tick, exp_tick);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    task automatic pulse_update();
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!period_tick && n < max);
        chk("tick_seen", int'(period_tick), 1);
    endtask

    int hi[NCH];
    int ticks, run0, maxrun0, miss;

    task automatic count(input int n, input logic [NCH-1:0] pat);
        ticks = 0; run0 = 0; maxrun0 = 0; miss = 0;
        for (int k = 0; k < NCH; k++) hi[k] = 0;
        repeat (n) begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) hi[k] += int'(pwm_out[k]);
            ticks += int'(period_tick);
            run0 = pwm_out[0] ? run0 + 1 : 0;
            if (run0 > maxrun0) maxrun0 = run0;
            if (pwm_out !== pat) miss++;
        end
    endtask

    int n, hi_a, hi_b, tk;

    initial begin
        rst = 1'b1; enable = 1'b0; period = '0; duty = '0; mode = 1'b0;
        polarity = '0; update = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm_out), 0);
        chk("reset_tick", int'(period_tick), 0);
        rst = 1'b0;
        enable = 1'b1;

        // Edge mode, P=10
        period = 10; mode = 1'b0; set_duty(0, 10, 5, 12);
        pulse_update();
        wait_tick(30, n);
        count(40, '0);
        chk("edge_hi_ch0", hi[0], 0);
        chk("edge_hi_ch1", hi[1], 40);
        chk("edge_hi_ch2", hi[2], 20);
        chk("edge_hi_ch3", hi[3], 40);
        chk("edge_ticks", ticks, 4);

        // Center mode, P=10, duty 5
        mode = 1'b1; set_duty(5, 0, 0, 0);
        pulse_update();
        wait_tick(30, n);
        count(40, '0);
        chk("ctr_hi_ch0", hi[0], 20);
        chk("ctr_hi_ch1", hi[1], 0);
        chk("ctr_pulse_len", maxrun0, 10);
        chk("ctr_ticks", ticks, 2);

        // Duty change mid-period: 3 -> 7 presented while cnt=4
        mode = 1'b0; set_duty(3, 0, 0, 0);
        pulse_update();
        wait_tick(40, n);
        hi_a = 0; hi_b = 0; tk = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 4) begin
                set_duty(7, 0, 0, 0);
                update = 1'b1;
            end
            if (i == 5) update = 1'b0;
            if (i <= 10) hi_a += int'(pwm_out[0]);
            else hi_b += int'(pwm_out[0]);
            tk += int'(period_tick);
        end
        chk("dbuf_old_period", hi_a, 3);
        chk("dbuf_new_period", hi_b, 7);
        chk("dbuf_ticks", tk, 2);

        // Disabled: outputs equal polarity, no ticks
        polarity = 4'b0101; enable = 1'b0;
        count(10, 4'b0101);
        chk("dis_pattern_miss", miss, 0);
        chk("dis_ticks", ticks, 0);
        set_duty(0, 0, 0, 0);
        pulse_update();
        enable = 1'b1;
        count(20, 4'b0101);
        chk("en_zero_duty_miss", miss, 0);

        // Update coinciding with boundary, P 10 -> 4
        wait_tick(20, n);
        for (int i = 1; i <= 9; i++) @(negedge clk);
        period = 4;
        update = 1'b1;
        @(negedge clk);
        update = 1'b0;
        chk("bnd_tick", int'(period_tick), 1);
        wait_tick(20, n);
        chk("bnd_next_tick_gap", n, 4);

        // Reset mid-period
        polarity = '0; set_duty(2, 2, 2, 2);
        pulse_update();
        wait_tick(20, n);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_tick", int'(period_tick), 0);
        rst = 1'b0;
        count(10, 4'b0000);
        chk("post_rst_miss", miss, 0);
        chk("post_rst_ticks", ticks, 0);
        polarity = 4'b1010;
        repeat (2) @(negedge clk);
        chk("p0_polarity_live", int'(pwm_out), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator. All channels share one period counter; each channel has its own duty compare.
- Adds edge-aligned and center-aligned modes.
- Duty, period and mode are double-buffered and switch only at a period boundary, so outputs never glitch.
- Drives motor/LED/servo outputs in the peripheral subsystem, one register interface per instance.

Parameters:
NUM_CH, 4, number of PWM output channels (1..16)
CNT_W, 16, width of the counter, period and duty fields

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  1 = run the counter; 0 = hold outputs at idle level
period  in  CNT_W  period value written into the shadow register on update
duty  in  NUM_CH*CNT_W  per-channel duty; channel k is at [k*CNT_W +: CNT_W]
mode  in  1  0 = edge-aligned, 1 = center-aligned (shadowed)
polarity  in  NUM_CH  per-channel output inversion (live, not shadowed)
update  in  1  one-cycle pulse: capture period/duty/mode into shadow and set the pending flag
pwm_out  out  NUM_CH  registered PWM outputs
period_tick  out  1  one-cycle pulse on each period boundary

Behaviour:
- Reset: counter=0, dir=up, active and shadow regs=0, pending=0, pwm_out=0, period_tick=0.
- Edge mode, active period P>0: cnt runs 0..P-1, then wraps to 0. Boundary is the cycle where cnt==P-1.
- Center mode, P>0: up phase 0..P-1 (P cycles), then down phase P-1..0 (P cycles). Full period is 2P cycles. Boundary is the cycle where cnt==0 with dir=down.
- Raw compare per channel: raw_k = (cnt < duty_k_active). Both modes use this rule.
  - duty=0: output always low.
  - duty>=P: output always high, with no glitch at the boundary.
- Output register: pwm_out[k] <= raw_k ^ polarity[k]. pwm_out lags cnt by one cycle.
- period_tick is registered and asserts the cycle after the boundary cycle.
- update pulse: shadow <= {period, duty, mode} and pending <= 1. A second update before the boundary overwrites the shadow; the last one wins.
- At a boundary with pending=1:
  - active <= shadow; pending <= 0.
  - Counter restarts at 0, dir=up.
  - The new values take effect for the first count of the next period.
- update on the same cycle as a boundary: the freshly presented inputs are loaded directly into active.
- Active P==0:
  - Counter held at 0; every cycle counts as a boundary, so pending loads apply on the next cycle.
  - raw=0, so pwm_out = polarity.
  - period_tick stays 0.
- enable=0:
  - Counter held at 0, dir=up; raw forced to 0, so pwm_out = polarity.
  - Pending loads apply immediately.
  - On rising enable, counting starts at 0 the same cycle.
- Mid-operation reset overrides everything: all state returns to reset values on the next edge.
- A period change takes effect only through the shadow path. A live period input below the current cnt has no effect.
- Width rules:
  - All comparisons are unsigned CNT_W.
  - P = 2^CNT_W-1 is legal.
  - Center mode with large P needs no extra bit: the full-period count is never stored.

Decomposition:
- Package pwm_pkg holds: mode encoding (PWM_EDGE=0, PWM_CENTER=1), default CNT_W, and a typedef for the shadow/active register bundle.
- Sub-module pwm_channel_cmp (compare, polarity XOR, output flop; parameter CNT_W) is instantiated NUM_CH times via generate.
- The shared counter, direction, shadow/pending logic and period_tick stay in pwm_multi.

Test Plan:
- Edge mode, P=10; duty ch0..3 = 0, 10, 5, 12; update; run 40 cycles after the first tick. Expected high counts: ch0=0, ch1=40, ch2=20, ch3=40; period_tick every 10 cycles.
- Center mode, P=10, duty ch0=5; 40 cycles. Expected: ch0 high 20; each high pulse 10 cycles long, centered on the counter trough; period_tick every 20 cycles.
- Running at P=10, duty=3; update to duty=7 at cnt=4. Expected: current period still shows 3 high cycles; next period shows 7; no runt pulse.
- polarity=4'b0101 with enable=0. Expected: pwm_out=4'b0101 steady, period_tick=0. Then enable=1 with duty=0 everywhere: output stays 4'b0101.
- update and boundary on the same cycle (P 10 -> 4). Expected: the next tick comes 4 cycles later.
- Assert rst mid-period. Expected: next cycle pwm_out=0, period_tick=0. After release with no update: outputs stay low, with active P=0.
